// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streaming F x F x D convolution with K filters over an H x W raster frame
module conv_layer_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int D = 3,
  parameter int K = 4,
  parameter int H = 9,
  parameter int W = 9,
  parameter int F = 3,
  parameter int STRIDE = 1,
  parameter int RELU = 0,
  localparam int OH = (H - F) / STRIDE + 1,
  localparam int OW = (W - F) / STRIDE + 1,
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(F * F * D),
  localparam int NC = K * D * F * F,
  localparam int CAW = $clog2(NC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [CAW-1:0]          coef_addr,
  input  logic [DATA_WIDTH-1:0]   coef_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [D*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*ACC_W-1:0]      out_data,
  output logic                    out_last,
  output logic                    done,
  output logic                    busy,
  output logic                    cfg_err
);
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int NB = OH * OW;
  localparam int OBW = $clog2(NB + 1);
  localparam int PW = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [OBW-1:0] ob;
  logic signed [DATA_WIDTH-1:0] coef [NC];
  logic signed [DATA_WIDTH-1:0] lb [F-1][W][D];
  logic signed [DATA_WIDTH-1:0] win [F][F][D];
  logic signed [DATA_WIDTH-1:0] nwin [F][F][D];
  logic signed [ACC_W-1:0] res [K];
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0] p;
  logic accept, xfer, last_px, emit;
  assign in_ready = state != FLUSH && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign done = xfer && out_last;
  assign busy = state != IDLE;
  assign last_px = row == RW'(H - 1) && col == CW'(W - 1);
  // top-left row/col offsets are even exactly when row/col are even, since F-1 is even
  assign emit = accept && row >= RW'(F - 1) && col >= CW'(F - 1) && (STRIDE == 1 || (!row[0] && !col[0]));
  always_comb state_n = (accept && last_px) ? FLUSH : accept ? RUN : (state == FLUSH && done) ? IDLE : state;
  // window as it will be after this pixel shifts in; results are computed from it directly
  always_comb begin
    nwin = win;
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F - 1; c++)
        nwin[r][c] = win[r][c+1];
    for (int r = 0; r < F - 1; r++)
      nwin[r][F-1] = lb[F-2-r][col];
    for (int d = 0; d < D; d++)
      nwin[F-1][F-1][d] = in_data[d*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    acc = '0;
    p = '0;
    for (int k = 0; k < K; k++) begin
      acc = '0;
      for (int d = 0; d < D; d++)
        for (int r = 0; r < F; r++)
          for (int c = 0; c < F; c++) begin
            p = PW'(nwin[r][c][d]) * PW'(coef[((k*D+d)*F+r)*F+c]);
            acc = acc + {{(ACC_W-PW){p[PW-1]}}, p};
          end
      res[k] = (RELU != 0 && acc[ACC_W-1]) ? '0 : acc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      ob <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int r = 0; r < F - 1; r++)
        for (int c = 0; c < W; c++)
          for (int d = 0; d < D; d++) lb[r][c][d] <= '0;
      for (int r = 0; r < F; r++)
        for (int c = 0; c < F; c++)
          for (int d = 0; d < D; d++) win[r][c][d] <= '0;
    end else begin
      state <= state_n;
      cfg_err <= coef_we && state != IDLE;
      if (coef_we && state == IDLE && 32'(coef_addr) < NC) coef[coef_addr] <= coef_data;
      if (accept) begin
        col <= (col == CW'(W - 1)) ? '0 : col + 1'b1;
        row <= (col != CW'(W - 1)) ? row : (row == RW'(H - 1)) ? '0 : row + 1'b1;
        win <= nwin;
        for (int d = 0; d < D; d++) lb[0][col][d] <= in_data[d*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i < F - 1; i++) lb[i][col] <= lb[i-1][col];
      end else if (done) begin
        row <= '0;
        col <= '0;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_last <= ob == OBW'(NB - 1);
        ob <= ob + 1'b1;
        for (int k = 0; k < K; k++) out_data[k*ACC_W +: ACC_W] <= res[k];
      end else if (out_ready) out_valid <= 1'b0;
      if (done) ob <= '0;
    end
  end
endmodule

// File: doc/conv_layer_stream.md
CONV_LAYER_STREAM -- requirements
Module: conv_layer_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of pixels and coefficients.
REQ-002 SHALL have parameter D, default 3, input channel count.
REQ-003 SHALL have parameter K, default 4, filter (output channel) count.
REQ-004 SHALL have parameters H, W, defaults 9, 9, input frame height and width in pixels.
REQ-005 SHALL have parameter F, default 3, square kernel size, odd, F<=H, F<=W.
REQ-006 SHALL have parameter STRIDE, default 1, legal values 1 or 2; (H-F) and (W-F) divisible by STRIDE.
REQ-007 SHALL have parameter RELU, default 0; 1 clamps negative results to 0.
REQ-008 SHALL define derived constants OH=(H-F)/STRIDE+1, OW=(W-F)/STRIDE+1, ACC_W=2*DATA_WIDTH+clog2(F*F*D).
REQ-009 clk  input  1  rising-edge clock, sole clock domain.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  clog2(K*D*F*F)  coefficient index = ((k*D+d)*F+fr)*F+fc, fr=0 is top kernel row.
REQ-013 coef_data  input  DATA_WIDTH  coefficient value.
REQ-014 in_valid / in_ready  input / output  1 each  pixel beat handshake; transfer when both high.
REQ-015 in_data  input  D*DATA_WIDTH  one pixel, channel d at [d*DATA_WIDTH +: DATA_WIDTH], raster order.
REQ-016 out_valid / out_ready  output / input  1 each  result beat handshake.
REQ-017 out_data  output  K*ACC_W  filter k result at [k*ACC_W +: ACC_W].
REQ-018 out_last  output  1  high with final output beat (index OH*OW-1) of a frame.
REQ-019 done  output  1  one-cycle pulse when frame's final output beat transfers.
REQ-020 busy  output  1  high in RUN or FLUSH.
REQ-021 cfg_err  output  1  one-cycle pulse when coef_we asserted outside IDLE.

Function
REQ-022 SHALL store K*D*F*F coefficients; write takes effect on the clock edge of coef_we in IDLE; writes outside IDLE ignored, cfg_err pulses next cycle.
REQ-023 SHALL hold F-1 line buffers of W pixels (D channels each) plus an F x F x D window register.
REQ-024 FSM states IDLE, RUN, FLUSH; IDLE->RUN on first accepted pixel; RUN->FLUSH when pixel H*W-1 accepted; FLUSH->IDLE when final output transfers.
REQ-025 SHALL track input row/col counters, wrapping col at W-1 and row at H-1; counters clear on FLUSH->IDLE.
REQ-026 Output window with top-left (r0,c0) SHALL be emitted when pixel (r0+F-1, c0+F-1) is accepted, for r0, c0 multiples of STRIDE, r0<=H-F, c0<=W-F; no other pixel emits.
REQ-027 Result k = sum over d,fr,fc of x[r0+fr][c0+fc][d]*w[k][d][fr][fc] (correlation, no flip), full-precision signed ACC_W, no overflow or rounding.
REQ-028 RELU=1: negative results replaced by 0 per filter independently.
REQ-029 Latency: out_valid rises one cycle after the emitting pixel is accepted.
REQ-030 Single output register: in_ready = (state!=FLUSH) && (!out_valid || out_ready); in_ready also high in IDLE under same output condition.
REQ-031 While out_valid && !out_ready, out_data, out_last, out_valid SHALL hold stable.
REQ-032 Simultaneous output transfer and new emitting pixel accepted: register reloads same cycle, out_valid stays high, no bubble.
REQ-033 Frame outputs SHALL be exactly OH*OW beats, raster order; next frame's pixels accepted only after return to IDLE; coefficients persist across frames.

Reset
REQ-034 On reset low, asynchronously: state IDLE, counters 0, out_valid 0, out_data 0, out_last 0, done 0, busy 0, cfg_err 0, window and line buffers 0; coefficients 0.
REQ-035 Reset mid-frame SHALL abort frame with no done pulse; after release, block accepts a fresh frame starting at pixel (0,0).

Verification
REQ-036 Defaults, all coefs 2, all pixels 1, out_ready=1 -> 49 beats, every filter value 54, out_last and done on beat 49 only.
REQ-037 STRIDE=2, same stimulus -> 16 beats, all values 54; beat 16 out_last.
REQ-038 RELU=1, filter 0 coefs -1, others 1, pixels 1 -> filter 0 = 0, filters 1..3 = 27 every beat; RELU=0 filter 0 = -27.
REQ-039 out_ready toggled 1-of-3 cycles with random in_valid -> results identical to REQ-036, out_data stable while stalled, no beat lost or duplicated.
REQ-040 coef_we during RUN -> cfg_err pulse, coefficient unchanged; reset asserted at pixel 40 then full frame -> exactly 49 correct beats, one done.
